// File: rtl/testio_slave.sv
// Target end of the bit-serial testio link: deserialises a request frame, replays it
// as one mem_if transaction and serialises the ack/data response back onto the line.
module testio_slave #(
    parameter logic [15:0] TID       = 16'h0,
    parameter int          TIMEOUT_W = 8
) (
    input  logic        ti_clk_i,
    input  logic        ti_rst_i,
    input  logic        ti_dat_i,
    output logic        ti_dat_o,
    output logic        ti_dat_oen,
    output logic        ti_busy_o,
    output logic [7:0]  ti_err_cnt_o,
    output logic        mem_if_req_valid,
    input  logic        mem_if_req_ready,
    output logic [86:0] mem_if_req,
    input  logic        mem_if_resp_valid,
    output logic        mem_if_resp_ready,
    input  logic [50:0] mem_if_resp
);

    typedef enum logic [3:0] {
        IDLE, RX, REQ, WAIT, TX_TURN, TX_START, TX_ACK, TX_DATA, TX_PAR, TX_STOP
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TMO_ONE = 1;

    state_t               state, state_nx;
    logic [6:0]           bit_cnt;
    logic [67:0]          shift;
    logic                 wr, par, ack;
    logic [TIMEOUT_W-1:0] tmo;
    logic [31:0]          rdata;
    logic                 rpar;
    logic                 dout_nx, oen_nx;
    logic [6:0]           pay_len, stop_idx;
    logic                 rx_last, tmo_sat, send_data;
    logic                 unused_resp;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Bit 0 of a frame is W, so the payload length is only meaningful from bit 1 on.
    assign pay_len     = wr ? 7'd69 : 7'd33;
    assign stop_idx    = pay_len + 7'd1;
    assign rx_last     = (state == RX) && (bit_cnt == stop_idx);
    assign tmo_sat     = &tmo;
    assign send_data   = ~wr & ack;
    assign unused_resp = ^mem_if_resp[50:32];

    assign ti_busy_o         = (state != IDLE);
    assign mem_if_req_valid  = (state == REQ);
    assign mem_if_resp_ready = (state == WAIT);
    assign mem_if_req = {wr ? 3'd1 : 3'd0, TID,
                         wr ? shift[67:36] : shift[31:0],
                         wr ? shift[35:32] : 4'hF,
                         wr ? shift[31:0]  : 32'h0};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (!ti_dat_i) state_nx = RX;
            RX: begin
                if (rx_last) begin
                    if (!ti_dat_i)  state_nx = IDLE;
                    else if (par)   state_nx = TX_TURN;
                    else            state_nx = REQ;
                end
            end
            REQ:      if (mem_if_req_ready) state_nx = WAIT;
            WAIT:     if (mem_if_resp_valid || tmo_sat) state_nx = TX_TURN;
            TX_TURN:  state_nx = TX_START;
            TX_START: state_nx = TX_ACK;
            TX_ACK:   state_nx = send_data ? TX_DATA : TX_PAR;
            TX_DATA:  if (bit_cnt == 7'd31) state_nx = TX_PAR;
            TX_PAR:   state_nx = TX_STOP;
            TX_STOP:  state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase

        // Line outputs are registered, so they are decoded from the state being entered.
        dout_nx = 1'b1;
        oen_nx  = 1'b1;
        case (state_nx)
            TX_TURN:  oen_nx = 1'b0;
            TX_START: begin oen_nx = 1'b0; dout_nx = 1'b0; end
            TX_ACK:   begin oen_nx = 1'b0; dout_nx = ack; end
            TX_DATA:  begin oen_nx = 1'b0; dout_nx = (state == TX_DATA) ? rdata[30] : rdata[31]; end
            TX_PAR:   begin oen_nx = 1'b0; dout_nx = ack ^ (send_data & rpar); end
            TX_STOP:  oen_nx = 1'b0;
            default:  ;
        endcase
    end

    always_ff @(posedge ti_clk_i or posedge ti_rst_i) begin
        if (ti_rst_i) begin
            state        <= IDLE;
            ti_dat_o     <= 1'b1;
            ti_dat_oen   <= 1'b1;
            ti_err_cnt_o <= 8'h00;
            bit_cnt      <= 7'd0;
            shift        <= 68'h0;
            wr           <= 1'b0;
            par          <= 1'b0;
            ack          <= 1'b0;
            tmo          <= '0;
        end else begin
            state      <= state_nx;
            ti_dat_o   <= dout_nx;
            ti_dat_oen <= oen_nx;
            case (state)
                IDLE: begin
                    bit_cnt <= 7'd0;
                    par     <= 1'b0;
                end
                RX: begin
                    bit_cnt <= bit_cnt + 7'd1;
                    if (bit_cnt == 7'd0) wr <= ti_dat_i;
                    if (bit_cnt != 7'd0 && bit_cnt < pay_len) shift <= {shift[66:0], ti_dat_i};
                    if (bit_cnt < stop_idx) par <= par ^ ti_dat_i;
                    if (rx_last) begin
                        if (!ti_dat_i) begin
                            ti_err_cnt_o <= sat_inc(ti_err_cnt_o);
                        end else if (par) begin
                            ack          <= 1'b0;
                            ti_err_cnt_o <= sat_inc(ti_err_cnt_o);
                        end
                    end
                end
                REQ: tmo <= '0;
                WAIT: begin
                    // A response arriving on the timeout cycle still counts as an ack.
                    if (mem_if_resp_valid) begin
                        ack <= 1'b1;
                    end else if (tmo_sat) begin
                        ack          <= 1'b0;
                        ti_err_cnt_o <= sat_inc(ti_err_cnt_o);
                    end else begin
                        tmo <= tmo + TMO_ONE;
                    end
                end
                TX_ACK:  bit_cnt <= 7'd0;
                TX_DATA: bit_cnt <= bit_cnt + 7'd1;
                default: ;
            endcase
        end
    end

    // Read data shifts out MSB first; its parity is captured before shifting starts.
    always_ff @(posedge ti_clk_i) begin
        if (state == WAIT && mem_if_resp_valid) begin
            rdata <= mem_if_resp[31:0];
            rpar  <= ^mem_if_resp[31:0];
        end else if (state == TX_DATA) begin
            rdata <= {rdata[30:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_testio_slave.sv
// Directed bench for testio_slave: drives serial frames, answers mem_if requests and
// scoreboards both the mem_if requests and the serial response bits.
module tb_testio_slave;

    localparam logic [15:0] TID = 16'h5A3C;

    logic        clk = 1'b0;
    logic        rst, din, dat_o, oen, busy;
    logic [7:0]  err;
    logic        req_valid, req_ready;
    logic [86:0] req;
    logic        resp_valid, resp_ready;
    logic [50:0] resp;

    int total = 0, passed = 0, fails = 0, hs_cnt = 0, last_wait = 0;
    logic [86:0] exp_req_q[$];
    logic        exp_bit_q[$];

    always #5 clk = ~clk;

    testio_slave #(.TID(TID), .TIMEOUT_W(8)) dut (
        .ti_clk_i(clk), .ti_rst_i(rst), .ti_dat_i(din), .ti_dat_o(dat_o),
        .ti_dat_oen(oen), .ti_busy_o(busy), .ti_err_cnt_o(err),
        .mem_if_req_valid(req_valid), .mem_if_req_ready(req_ready), .mem_if_req(req),
        .mem_if_resp_valid(resp_valid), .mem_if_resp_ready(resp_ready), .mem_if_resp(resp)
    );

    always @(posedge clk) if (req_valid && req_ready) hs_cnt <= hs_cnt + 1;

    task automatic chk(input string tag, input logic [86:0] obs, input logic [86:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_dout"}, dat_o, 1'b1);
        chk({tag, "_oen"}, oen, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err"}, err, 8'h00);
        chk({tag, "_reqv"}, req_valid, 1'b0);
        chk({tag, "_rspr"}, resp_ready, 1'b0);
    endtask

    task automatic send_frame(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                              input logic [31:0] data, input logic flip, input logic stop,
                              input int abort_at);
        logic q[$];
        logic p;
        q.push_back(1'b0);
        q.push_back(wr);
        for (int i = 31; i >= 0; i--) q.push_back(addr[i]);
        p = wr ^ (^addr);
        if (wr) begin
            for (int i = 3; i >= 0; i--) q.push_back(strb[i]);
            for (int i = 31; i >= 0; i--) q.push_back(data[i]);
            p = p ^ (^strb) ^ (^data);
        end
        q.push_back(p ^ flip);
        q.push_back(stop);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            if (i == abort_at) begin
                rst = 1'b1;
                #1 reset_checks("rst_rx");
                @(negedge clk);
                rst = 1'b0;
                din = 1'b1;
                return;
            end
            din = q[i];
        end
        @(negedge clk);
        din = 1'b1;
        if (!flip && stop)
            exp_req_q.push_back({wr ? 3'd1 : 3'd0, TID, addr, wr ? strb : 4'hF, wr ? data : 32'h0});
    endtask

    task automatic push_resp(input logic ack, input logic with_data, input logic [31:0] d);
        logic p;
        exp_bit_q.push_back(1'b1);
        exp_bit_q.push_back(1'b0);
        exp_bit_q.push_back(ack);
        p = ack;
        if (with_data) begin
            for (int i = 31; i >= 0; i--) begin
                exp_bit_q.push_back(d[i]);
                p = p ^ d[i];
            end
        end
        exp_bit_q.push_back(p);
        exp_bit_q.push_back(1'b1);
    endtask

    task automatic wait_req(input int hold);
        int n;
        logic [86:0] e;
        n = 0;
        while (!req_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", req_valid, 1'b1);
        e = (exp_req_q.size() > 0) ? exp_req_q.pop_front() : 'x;
        chk("req_fields", req, e);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk("req_hold", req, e);
            chk("req_hold_vld", req_valid, 1'b1);
            req_ready = 1'b1;
        end
        @(negedge clk);
        chk("req_done", req_valid, 1'b0);
    endtask

    task automatic give_resp(input logic [31:0] d, input int delay);
        repeat (delay) @(negedge clk);
        chk("resp_rdy", resp_ready, 1'b1);
        resp_valid = 1'b1;
        resp = {3'd0, TID, d};
        @(negedge clk);
        resp_valid = 1'b0;
        chk("resp_taken", resp_ready, 1'b0);
        chk("turn_oen", oen, 1'b0);
    endtask

    task automatic collect_resp(input int budget);
        int n;
        logic b;
        n = 0;
        while (oen && n < budget) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        chk("resp_drive", oen, 1'b0);
        while (exp_bit_q.size() > 0) begin
            b = exp_bit_q.pop_front();
            chk("resp_bit", dat_o, b);
            chk("resp_oen", oen, 1'b0);
            @(negedge clk);
        end
        chk("resp_release", oen, 1'b1);
        chk("resp_idle", busy, 1'b0);
    endtask

    initial begin
        int  h;
        logic drv;
        rst = 1'b1; din = 1'b1; req_ready = 1'b1; resp_valid = 1'b0; resp = '0;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst = 1'b0;
        @(negedge clk);

        // Write transaction
        send_frame(1'b1, 32'h1000_0040, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1, -1);
        push_resp(1'b1, 1'b0, 32'h0);
        wait_req(0);
        give_resp(32'h1234_5678, 2);
        collect_resp(10);
        chk("t1_err", err, 8'd0);

        // Read transaction with req_ready held off
        req_ready = 1'b0;
        send_frame(1'b0, 32'h0000_0100, 4'h0, 32'h0, 1'b0, 1'b1, -1);
        push_resp(1'b1, 1'b1, 32'hA5A5_0F0F);
        wait_req(3);
        give_resp(32'hA5A5_0F0F, 0);
        collect_resp(10);

        // Parity error
        h = hs_cnt;
        send_frame(1'b1, 32'h2000_0000, 4'h3, 32'h0123_4567, 1'b1, 1'b1, -1);
        push_resp(1'b0, 1'b0, 32'h0);
        collect_resp(10);
        chk("par_noreq", hs_cnt, h);
        chk("par_err", err, 8'd1);

        // Framing error then a good read
        h = hs_cnt;
        send_frame(1'b0, 32'h0000_0300, 4'h0, 32'h0, 1'b0, 1'b0, -1);
        drv = 1'b0;
        repeat (8) begin
            if (!oen) drv = 1'b1;
            @(negedge clk);
        end
        chk("frm_oen", drv, 1'b0);
        chk("frm_err", err, 8'd2);
        chk("frm_busy", busy, 1'b0);
        chk("frm_noreq", hs_cnt, h);
        send_frame(1'b0, 32'h0000_0400, 4'h0, 32'h0, 1'b0, 1'b1, -1);
        push_resp(1'b1, 1'b1, 32'h8000_0001);
        wait_req(0);
        give_resp(32'h8000_0001, 1);
        collect_resp(10);

        // Response timeout, then a late response while idle
        send_frame(1'b0, 32'h0000_0500, 4'h0, 32'h0, 1'b0, 1'b1, -1);
        push_resp(1'b0, 1'b0, 32'h0);
        wait_req(0);
        collect_resp(400);
        chk("tmo_len", (last_wait >= 255) && (last_wait <= 257), 1'b1);
        chk("tmo_err", err, 8'd3);
        h = hs_cnt;
        resp_valid = 1'b1;
        resp = {3'd0, TID, 32'h5555_AAAA};
        #1 chk("late_rdy", resp_ready, 1'b0);
        @(negedge clk);
        resp_valid = 1'b0;
        chk("late_busy", busy, 1'b0);
        chk("late_noreq", hs_cnt, h);

        // Reset mid-RX, then a good write
        h = hs_cnt;
        send_frame(1'b0, 32'h0000_0600, 4'h0, 32'h0, 1'b0, 1'b1, 20);
        repeat (5) @(negedge clk);
        chk("rx_rst_noreq", hs_cnt, h);
        chk("rx_rst_busy", busy, 1'b0);
        send_frame(1'b1, 32'h0000_0700, 4'hA, 32'hCAFE_F00D, 1'b0, 1'b1, -1);
        push_resp(1'b1, 1'b0, 32'h0);
        wait_req(0);
        give_resp(32'h0, 0);
        collect_resp(10);
        chk("rx_rst_err", err, 8'd0);

        // Reset mid-TX_DATA, then a good read
        send_frame(1'b0, 32'h0000_0800, 4'h0, 32'h0, 1'b0, 1'b1, -1);
        wait_req(0);
        give_resp(32'hFFFF_0000, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1 reset_checks("rst_tx");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("tx_rst_busy", busy, 1'b0);
        send_frame(1'b0, 32'h0000_0900, 4'h0, 32'h0, 1'b0, 1'b1, -1);
        push_resp(1'b1, 1'b1, 32'h0F1E_2D3C);
        wait_req(0);
        give_resp(32'h0F1E_2D3C, 0);
        collect_resp(10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
